// File: rtl/acc_ctrl_pkg.sv
// Shared constants and FSM state type for the ACC control serial link receiver.
package acc_ctrl_pkg;

  localparam logic [7:0]  ACC_HEADER        = 8'h5A;
  localparam logic [15:0] ACC_NORMAL_CLASS0 = 16'h5A50;
  localparam logic [15:0] ACC_NORMAL_CLASS1 = 16'h5A51;
  localparam logic [15:0] ACC_NORMAL_CLASS2 = 16'h5A52;
  localparam logic [15:0] ACC_NORMAL_CLASS3 = 16'h5A53;
  localparam logic [15:0] ACC_NORMAL_CLASS4 = 16'h5A54;
  localparam logic [15:0] ACC_NORMAL_CLASS5 = 16'h5A55;
  localparam logic [15:0] ACC_NORMAL_CLASS6 = 16'h5A56;
  localparam logic [15:0] ACC_NORMAL_CLASS7 = 16'h5A57;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } acc_rx_state_e;

endpackage

// File: rtl/acc_serial_deser.sv
// Link synchroniser, SCLK rising-edge detector and MSB-first beat shifter.
module acc_serial_deser #(
  parameter int DATA_WIDTH  = 16,
  parameter int SERIAL_MODE = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sclk_i,
  input  logic [SERIAL_MODE-1:0] miso_i,
  input  logic                   clr_i,
  output logic                   beat_rise_o,
  output logic [DATA_WIDTH-1:0]  word_o
);

  // [0]=s1, [1]=s2, [2]=s3; reset high so a line held high through reset gives no edge
  logic [2:0]             sclk_q;
  logic [SERIAL_MODE-1:0] miso_s1_q, miso_s2_q;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic                   rise;

  assign rise = sclk_q[1] & ~sclk_q[2];

  always_comb begin
    word_d = word_q;
    if (clr_i)     word_d = '0;
    else if (rise) word_d = {word_q[DATA_WIDTH-SERIAL_MODE-1:0], miso_s2_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q    <= 3'b111;
      miso_s1_q <= '0;
      miso_s2_q <= '0;
      word_q    <= '0;
    end else begin
      sclk_q    <= {sclk_q[1:0], sclk_i};
      miso_s1_q <= miso_i;
      miso_s2_q <= miso_s1_q;
      word_q    <= word_d;
    end
  end

  assign beat_rise_o = rise;
  assign word_o      = word_q;

endmodule

// File: rtl/acc_ctrl_rx_drv.sv
// ACC control link receive driver: word framing FSM, header check and class decode.
// Optional ACC_RX_STATS_EN adds good-frame and error counters.
module acc_ctrl_rx_drv
  import acc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int SERIAL_MODE  = 1,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   SPI_SCLK,
  input  logic [SERIAL_MODE-1:0] SPI_MISO,
  output logic                   rx_valid_o,
  output logic [DATA_WIDTH-1:0]  rx_data_o,
  output logic [2:0]             acc_class_o,
  output logic                   acc_ctrl_o,
  output logic                   hdr_err_o,
  output logic                   timeout_err_o
`ifdef ACC_RX_STATS_EN
  ,
  output logic [15:0]            frame_cnt_o,
  output logic [15:0]            err_cnt_o
`endif
);

  localparam int BEATS = DATA_WIDTH / SERIAL_MODE;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int TW    = $clog2(IDLE_TIMEOUT + 1);

  acc_rx_state_e         state_q, state_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]         idle_cnt_q, idle_cnt_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  hdr_err_q, hdr_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [2:0]            acc_class_q, acc_class_d;
  logic                  acc_ctrl_q, acc_ctrl_d;
  logic                  rise, shift_clr, hdr_good;
  logic [DATA_WIDTH-1:0] word;

  acc_serial_deser #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SERIAL_MODE (SERIAL_MODE)
  ) u_deser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sclk_i      (SPI_SCLK),
    .miso_i      (SPI_MISO),
    .clr_i       (shift_clr),
    .beat_rise_o (rise),
    .word_o      (word)
  );

  assign hdr_good = (word[15:8] == ACC_HEADER);

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    rx_valid_d    = 1'b0;
    hdr_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    rx_data_d     = rx_data_q;
    acc_class_d   = acc_class_q;
    acc_ctrl_d    = acc_ctrl_q;
    shift_clr     = 1'b0;

    if (rise)                                   idle_cnt_d = '0;
    else if (idle_cnt_q != TW'(IDLE_TIMEOUT))   idle_cnt_d = idle_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          beat_cnt_d = CW'(1);
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        // a rise on the threshold cycle is accepted, so it takes priority
        if (rise) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CW'(BEATS - 1)) state_d = ST_CHECK;
        end else if (idle_cnt_q == TW'(IDLE_TIMEOUT)) begin
          timeout_err_d = 1'b1;
          shift_clr     = 1'b1;
          beat_cnt_d    = '0;
          state_d       = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (hdr_good) begin
          rx_valid_d  = 1'b1;
          rx_data_d   = word;
          acc_class_d = word[2:0];
          if (word[15:0] == ACC_NORMAL_CLASS1)      acc_ctrl_d = 1'b1;
          else if (word[15:0] == ACC_NORMAL_CLASS0) acc_ctrl_d = 1'b0;
        end else begin
          hdr_err_d = 1'b1;
        end
        // a rise here is beat 1 of the following word
        if (rise) begin
          beat_cnt_d = CW'(1);
          state_d    = ST_RECV;
        end else begin
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        beat_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      rx_valid_q    <= 1'b0;
      hdr_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      rx_data_q     <= '0;
      acc_class_q   <= '0;
      acc_ctrl_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      rx_valid_q    <= rx_valid_d;
      hdr_err_q     <= hdr_err_d;
      timeout_err_q <= timeout_err_d;
      rx_data_q     <= rx_data_d;
      acc_class_q   <= acc_class_d;
      acc_ctrl_q    <= acc_ctrl_d;
    end
  end

  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign acc_class_o   = acc_class_q;
  assign acc_ctrl_o    = acc_ctrl_q;
  assign hdr_err_o     = hdr_err_q;
  assign timeout_err_o = timeout_err_q;

`ifdef ACC_RX_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (rx_valid_d)                frame_cnt_d = frame_cnt_q + 16'd1;
    if (hdr_err_d | timeout_err_d) err_cnt_d   = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`endif

endmodule
